// File: rtl/jtframe_vid_timer_pkg.sv
// Shared video timing constants and helpers for the jtframe video blocks.
// Sibling blocks import this package so they all use one default 384x264 geometry.
package jtframe_vid_timer_pkg;

    localparam int CNT_W = 9;

    localparam int DEF_HTOTAL   = 384;
    localparam int DEF_HB_START = 256;
    localparam int DEF_HB_END   = 0;
    localparam int DEF_HS_START = 288;
    localparam int DEF_HS_END   = 320;

    localparam int DEF_VTOTAL   = 264;
    localparam int DEF_VB_START = 224;
    localparam int DEF_VB_END   = 0;
    localparam int DEF_VS_START = 240;
    localparam int DEF_VS_END   = 244;

    typedef logic [CNT_W-1:0] cnt_t;

    // Modulo increment; any value at or beyond 'last' folds back to zero.
    function automatic cnt_t wrap_inc(input cnt_t x, input cnt_t last);
        return (x >= last) ? '0 : cnt_t'(x + 1'b1);
    endfunction

endpackage

// File: rtl/jtframe_vid_range.sv
// Wrap-aware window decode: asserts when x lies in [S,E), wrapping past the
// counter end when S > E. An empty window (S == E) never asserts.
module jtframe_vid_range
    import jtframe_vid_timer_pkg::*;
(
    input  logic [8:0] x,
    input  logic [8:0] S,
    input  logic [8:0] E,
    output logic       in
);

    always_comb begin
        in = 1'b0;
        if (S < E) begin
            in = (x >= S) && (x < E);
        end else if (S > E) begin
            in = (x >= S) || (x < E);
        end
    end

endmodule

// File: rtl/jtframe_vid_timer.sv
// Pixel/line counters with blanking and sync flags for raster video timing.
// Flags are decoded from the next counter values so they line up with H/V.
module jtframe_vid_timer
    import jtframe_vid_timer_pkg::*;
#(
    parameter int HTOTAL   = DEF_HTOTAL,
    parameter int HB_START = DEF_HB_START,
    parameter int HB_END   = DEF_HB_END,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_END   = DEF_HS_END,
    parameter int VTOTAL   = DEF_VTOTAL,
    parameter int VB_START = DEF_VB_START,
    parameter int VB_END   = DEF_VB_END,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_END   = DEF_VS_END
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    output logic [8:0] H,
    output logic [8:0] V,
    output logic [8:0] Vrender,
    output logic       HBL,
    output logic       VBL,
    output logic       HS,
    output logic       VS,
    output logic       LHBL,
    output logic       LVBL,
    output logic       frame
);

    // Parameters are expected within 0..511 and totals of at least 2.
    localparam cnt_t H_LAST = cnt_t'(HTOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(VTOTAL - 1);
    localparam cnt_t VR_RST = cnt_t'(1);

    cnt_t h_q, h_d;
    cnt_t v_q, v_d;
    cnt_t vr_q, vr_d;
    logic frame_q, frame_d;
    logic hbl_q, hbl_d;
    logic hs_q, hs_d;
    logic vbl_q, vbl_d;
    logic vs_q, vs_d;

    logic h_wrap, h_bad, v_wrap, v_bad;

    assign h_wrap = (h_q == H_LAST);
    assign h_bad  = (h_q > H_LAST);
    assign v_wrap = (v_q == V_LAST);
    assign v_bad  = (v_q > V_LAST);

    // Reset is folded into the next values so the flag decode sees H=0,V=0.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (!rst_n) begin
            h_d     = '0;
            v_d     = '0;
            frame_d = 1'b0;
        end else if (pxl_cen) begin
            h_d = (h_wrap || h_bad) ? '0 : cnt_t'(h_q + 1'b1);
            if (v_bad) begin
                v_d = '0;
            end else if (h_wrap) begin
                v_d = v_wrap ? '0 : cnt_t'(v_q + 1'b1);
            end
            if (h_wrap && v_wrap) begin
                frame_d = ~frame_q;
            end
        end
        vr_d = wrap_inc(v_d, V_LAST);
    end

    jtframe_vid_range u_hbl (
        .x  (h_d),
        .S  (cnt_t'(HB_START)),
        .E  (cnt_t'(HB_END)),
        .in (hbl_d)
    );

    jtframe_vid_range u_hs (
        .x  (h_d),
        .S  (cnt_t'(HS_START)),
        .E  (cnt_t'(HS_END)),
        .in (hs_d)
    );

    jtframe_vid_range u_vbl (
        .x  (v_d),
        .S  (cnt_t'(VB_START)),
        .E  (cnt_t'(VB_END)),
        .in (vbl_d)
    );

    jtframe_vid_range u_vs (
        .x  (v_d),
        .S  (cnt_t'(VS_START)),
        .E  (cnt_t'(VS_END)),
        .in (vs_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            vr_q    <= VR_RST;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            vr_q    <= vr_d;
            frame_q <= frame_d;
        end
        hbl_q <= hbl_d;
        hs_q  <= hs_d;
        vbl_q <= vbl_d;
        vs_q  <= vs_d;
    end

    assign H       = h_q;
    assign V       = v_q;
    assign Vrender = vr_q;
    assign frame   = frame_q;
    assign HBL     = hbl_q;
    assign HS      = hs_q;
    assign VBL     = vbl_q;
    assign VS      = vs_q;
    assign LHBL    = ~hbl_q;
    assign LVBL    = ~vbl_q;

endmodule

// File: tb/tb_jtframe_vid_timer.sv
// Directed bench for jtframe_vid_timer: default geometry, a non-wrapping
// blank window and a tiny geometry that makes whole frames cheap to walk.
module tb_jtframe_vid_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pxl_cen = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    logic [8:0] d_H, d_V, d_Vr;
    logic d_HBL, d_VBL, d_HS, d_VS, d_LHBL, d_LVBL, d_frame;
    logic [8:0] w_H, w_V, w_Vr;
    logic w_HBL, w_VBL, w_HS, w_VS, w_LHBL, w_LVBL, w_frame;
    logic [8:0] s_H, s_V, s_Vr;
    logic s_HBL, s_VBL, s_HS, s_VS, s_LHBL, s_LVBL, s_frame;

    always #5 clk = ~clk;

    jtframe_vid_timer u_def (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .H(d_H), .V(d_V), .Vrender(d_Vr),
        .HBL(d_HBL), .VBL(d_VBL), .HS(d_HS), .VS(d_VS),
        .LHBL(d_LHBL), .LVBL(d_LVBL), .frame(d_frame)
    );

    jtframe_vid_timer #(.HB_START(10), .HB_END(300), .HS_START(50), .HS_END(50)) u_hb (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .H(w_H), .V(w_V), .Vrender(w_Vr),
        .HBL(w_HBL), .VBL(w_VBL), .HS(w_HS), .VS(w_VS),
        .LHBL(w_LHBL), .LVBL(w_LVBL), .frame(w_frame)
    );

    // 8 pixels x 6 lines: wrapping H blank 5..0, HS at 6, VBL 4..5, VS at 5.
    jtframe_vid_timer #(
        .HTOTAL(8), .HB_START(5), .HB_END(1), .HS_START(6), .HS_END(7),
        .VTOTAL(6), .VB_START(4), .VB_END(0), .VS_START(5), .VS_END(6)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .H(s_H), .V(s_V), .Vrender(s_Vr),
        .HBL(s_HBL), .VBL(s_VBL), .HS(s_HS), .VS(s_VS),
        .LHBL(s_LHBL), .LVBL(s_LVBL), .frame(s_frame)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pxl_cen = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        pxl_cen = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pxl_cen = 1'b0;
        tick();
        tick();
        n_total++;
        if ({d_H, d_V, d_Vr, d_frame} !== {9'd0, 9'd0, 9'd1, 1'b0})
            $display("[TB] FAIL reset_cnt got H=%0d V=%0d Vr=%0d fr=%b want 0 0 1 0", d_H, d_V, d_Vr, d_frame);
        else n_pass++;
        n_total++;
        if ({d_HBL, d_VBL, d_HS, d_VS, d_LHBL, d_LVBL} !== 6'b000011)
            $display("[TB] FAIL reset_flags got %b want 000011", {d_HBL, d_VBL, d_HS, d_VS, d_LHBL, d_LVBL});
        else n_pass++;
        n_total++;
        if ({s_HBL, s_VBL, s_HS, s_VS, s_LHBL, s_Vr} !== {4'b1000, 1'b0, 9'd1})
            $display("[TB] FAIL reset_small got %b Vr=%0d want 10000 Vr=1", {s_HBL, s_VBL, s_HS, s_VS, s_LHBL}, s_Vr);
        else n_pass++;
    endtask

    task automatic test_line_sequence();
        int h, v;
        do_reset();
        pxl_cen = 1'b1;
        for (int i = 1; i <= 770; i++) begin
            tick();
            h = i % 384;
            v = i / 384;
            n_total++;
            if ({d_H, d_V, d_Vr, d_frame} !== {9'(h), 9'(v), 9'(v + 1), 1'b0})
                $display("[TB] FAIL line_cnt i=%0d got H=%0d V=%0d Vr=%0d want %0d %0d %0d", i, d_H, d_V, d_Vr, h, v, v + 1);
            else n_pass++;
            n_total++;
            if ({d_HBL, d_HS, d_LHBL, d_VBL, d_VS} !== {h >= 256, (h >= 288 && h < 320), h < 256, 2'b00})
                $display("[TB] FAIL line_flags H=%0d got %b want %b", h, {d_HBL, d_HS, d_LHBL, d_VBL, d_VS},
                         {h >= 256, (h >= 288 && h < 320), h < 256, 2'b00});
            else n_pass++;
        end
    endtask

    task automatic test_cen_div4();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            pxl_cen = (k % 4 == 0);
            tick();
            n_total++;
            if ({d_H, d_V, d_HBL, d_HS} !== {9'(k / 4 + 1), 9'd0, 2'b00})
                $display("[TB] FAIL cen_div4 k=%0d got H=%0d V=%0d want H=%0d V=0", k, d_H, d_V, k / 4 + 1);
            else n_pass++;
        end
    endtask

    task automatic test_frames();
        int h, ln, v, fr;
        logic [5:0] want;
        do_reset();
        pxl_cen = 1'b1;
        for (int i = 1; i <= 97; i++) begin
            tick();
            h  = i % 8;
            ln = i / 8;
            v  = ln % 6;
            fr = (ln / 6) % 2;
            n_total++;
            if ({s_H, s_V, s_Vr, s_frame} !== {9'(h), 9'(v), 9'((v + 1) % 6), 1'(fr)})
                $display("[TB] FAIL frame_cnt i=%0d got H=%0d V=%0d Vr=%0d fr=%b want %0d %0d %0d %0d",
                         i, s_H, s_V, s_Vr, s_frame, h, v, (v + 1) % 6, fr);
            else n_pass++;
            want = {(h >= 5 || h < 1), h == 6, v >= 4, v == 5, !(h >= 5 || h < 1), v < 4};
            n_total++;
            if ({s_HBL, s_HS, s_VBL, s_VS, s_LHBL, s_LVBL} !== want)
                $display("[TB] FAIL frame_flags H=%0d V=%0d got %b want %b", h, v,
                         {s_HBL, s_HS, s_VBL, s_VS, s_LHBL, s_LVBL}, want);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        pxl_cen = 1'b1;
        repeat (150 * 384 + 100) tick();
        n_total++;
        if ({d_H, d_V} !== {9'd100, 9'd150})
            $display("[TB] FAIL midframe_pos got H=%0d V=%0d want 100 150", d_H, d_V);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_total++;
        if ({d_H, d_V, d_Vr, d_frame, d_HBL, d_VBL} !== {9'd0, 9'd0, 9'd1, 3'b000})
            $display("[TB] FAIL midframe_rst got H=%0d V=%0d Vr=%0d fr=%b hbl=%b vbl=%b want 0 0 1 0 0 0",
                     d_H, d_V, d_Vr, d_frame, d_HBL, d_VBL);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++;
        if ({d_H, d_V, d_Vr} !== {9'd1, 9'd0, 9'd1})
            $display("[TB] FAIL midframe_release got H=%0d V=%0d Vr=%0d want 1 0 1", d_H, d_V, d_Vr);
        else n_pass++;
    endtask

    task automatic test_hb_nonwrap();
        int h;
        do_reset();
        pxl_cen = 1'b1;
        for (int i = 1; i <= 384; i++) begin
            tick();
            h = i % 384;
            n_total++;
            if ({w_H, w_HBL, w_HS, w_LHBL} !== {9'(h), (h >= 10 && h < 300), 1'b0, !(h >= 10 && h < 300)})
                $display("[TB] FAIL hb_nonwrap H=%0d got H=%0d hbl=%b hs=%b want hbl=%b hs=0",
                         h, w_H, w_HBL, w_HS, (h >= 10 && h < 300));
            else n_pass++;
        end
    endtask

    task automatic test_recovery();
        do_reset();
        pxl_cen = 1'b1;
        repeat (5) tick();
        pxl_cen = 1'b0;
        force u_def.h_q = 9'd400;
        #1;
        release u_def.h_q;
        tick();
        n_total++;
        if (d_H !== 9'd400)
            $display("[TB] FAIL recov_hold got H=%0d want 400", d_H);
        else n_pass++;
        pxl_cen = 1'b1;
        tick();
        n_total++;
        if ({d_H, d_HBL, d_HS} !== {9'd0, 2'b00})
            $display("[TB] FAIL recov_zero got H=%0d hbl=%b hs=%b want 0 0 0", d_H, d_HBL, d_HS);
        else n_pass++;
        tick();
        n_total++;
        if (d_H !== 9'd1)
            $display("[TB] FAIL recov_resume got H=%0d want 1", d_H);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_line_sequence();
        test_cen_div4();
        test_frames();
        test_hb_nonwrap();
        test_reset_mid_frame();
        test_recovery();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jtframe_vid_timer.md
JTFRAME_VID_TIMER -- requirements
Module: jtframe_vid_timer

Interface
REQ-001 The block SHALL have parameter HTOTAL, default 384, meaning pixels per line.
REQ-002 The block SHALL have parameter HB_START, default 256, meaning first horizontal-blank pixel.
REQ-003 The block SHALL have parameter HB_END, default 0, meaning first active pixel after horizontal blank.
REQ-004 The block SHALL have parameter HS_START, default 288, meaning first HS pixel.
REQ-005 The block SHALL have parameter HS_END, default 320, meaning first pixel after HS.
REQ-006 The block SHALL have parameters VTOTAL 264, VB_START 224, VB_END 0, VS_START 240, VS_END 244, as the vertical equivalents, in lines.
REQ-007 clk  in  1  system clock; one clock domain, everything on its rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 pxl_cen  in  1  pixel clock enable, driven by cen[0] of the fractional cen generator.
REQ-010 H  out  9  horizontal pixel count.
REQ-011 V  out  9  vertical line count.
REQ-012 Vrender  out  9  next line to render, (V+1) mod VTOTAL.
REQ-013 HBL, VBL, HS, VS  out  1 each  blanking and sync, active-high.
REQ-014 LHBL, LVBL  out  1 each  active-low copies of HBL and VBL.
REQ-015 frame  out  1  toggles once per frame.

Function
REQ-016 All state and outputs SHALL change only on clk edges with pxl_cen=1; with pxl_cen=0 they SHALL hold.
REQ-017 On each pxl_cen edge:
  - H SHALL become H+1, or 0 when H==HTOTAL-1.
  - V SHALL advance only on the H wrap, becoming V+1, or 0 when V==VTOTAL-1.
  - frame SHALL toggle on the combined H and V wrap.
REQ-018 The range decode SHALL be: in(x,S,E) = (S<=x<E) when S<=E, else (x>=S or x<E); S==E means never.
REQ-019 HBL=in(H,HB_START,HB_END), HS=in(H,HS_START,HS_END), VBL=in(V,VB_START,VB_END), VS=in(V,VS_START,VS_END).
REQ-020 Flags SHALL be registered from the decode of the next counter values, so every flag is coherent with the H/V on the same cycle, with zero lag.
REQ-021 Vrender SHALL be registered alongside V, with the same coherency.
REQ-022 If H>=HTOTAL or V>=VTOTAL is ever observed, the next pxl_cen edge SHALL force that counter to 0; this is a recovery path only.
REQ-023 Counter arithmetic SHALL be 9-bit unsigned; parameters SHALL be <=511 and TOTALs >=2.
REQ-024 VBL, VS and Vrender SHALL change only on the cycle H wraps to 0.

Reset
REQ-025 While rst_n=0 at a clk edge (pxl_cen ignored):
  - H=0, V=0, Vrender=1 mod VTOTAL, frame=0.
  - Flags SHALL equal the decode at H=0,V=0, i.e. HBL=0, VBL=0, HS=0, VS=0, LHBL=1, LVBL=1 with default parameters.
REQ-026 A reset asserted mid-line or mid-frame SHALL take effect on that edge, with no partial-line completion.
REQ-027 After release, the first pxl_cen edge SHALL produce H=1.

Structure
REQ-028 Default timing constants (384/264 geometry) SHALL live in the shared jtframe include so sibling blocks share them.
REQ-029 The wrap-aware range compare SHALL be one sub-module, jtframe_vid_range (inputs x, S, E; output in), instantiated four times.
REQ-030 The block SHALL contain no other sub-modules; expected size is 150-250 RTL lines.

Verification
REQ-031 Scenario 1: defaults, pxl_cen=1 every cycle, from reset -> H sequence 0..383 then 0; V increments at the wrap; HBL=1 for H 256..383; HS=1 for H 288..319.
REQ-032 Scenario 2: pxl_cen from the fractional cen generator at n=1, m=4 -> H advances exactly once per 4 clk; no output changes on non-cen cycles.
REQ-033 Scenario 3: run 2 frames -> VBL=1 for V 224..263; VS=1 for V 240..243; frame toggles at V 263->0 with H 383->0; Vrender=0 while V=263; line period 384 cens; frame period 101376 cens.
REQ-034 Scenario 4: assert rst_n=0 at H=100, V=150 for 1 cycle -> next cycle H=0, V=0, Vrender=1, frame=0, HBL=0, VBL=0.
REQ-035 Scenario 5: HB_START=10, HB_END=300 (non-wrapping); HS_START=HS_END=50 -> HBL=1 exactly for H 10..299; HS never asserts.
REQ-036 Scenario 6: force H=400 via testbench -> the next pxl_cen edge gives H=0 and normal sequencing resumes.
